pd_crc32_check: RTL

PD_CRC32_CHECK -- requirements
Module: pd_crc32_check

---
 rtl/pd_crc_pkg.sv | 25 ++
 rtl/pd_crc32_lfsr.sv | 30 +++
 rtl/pd_crc32_check.sv | 111 +++++++++++
 3 files changed

// File: rtl/pd_crc_pkg.sv
// Shared CRC-32 (reflected) constants, checker state encoding and the byte-step function.
// Used by both the receive checker and the transmit-side generator.
package pd_crc_pkg;

    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Advance the reflected CRC register by one byte, LSB of the byte first.
    function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/pd_crc32_lfsr.sv
// Byte-wide CRC-32 register with a synchronous init-and-advance and an enable.
// Direction-agnostic, so the transmit-side generator can reuse it unchanged.
module pd_crc32_lfsr (
    input  logic        clock,
    input  logic        nrst,
    input  logic        i_init,
    input  logic        i_en,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc,
    output logic [31:0] o_crc_next
);
    import pd_crc_pkg::*;

    logic [31:0] r_crc;
    logic [31:0] w_base;

    // i_init seeds from CRC_INIT and folds in the current byte in the same cycle.
    assign w_base     = i_init ? CRC_INIT : r_crc;
    assign o_crc_next = crc32_step(w_base, i_data);
    assign o_crc      = r_crc;

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            r_crc <= CRC_INIT;
        end else if (i_en) begin
            r_crc <= o_crc_next;
        end
    end

endmodule

// File: rtl/pd_crc32_check.sv
// Receive-side CRC-32 frame checker: FSM, saturating byte counter and registered verdict.
// The CRC register itself lives in pd_crc32_lfsr.
module pd_crc32_check #(
    parameter int MAX_BYTES = 34,
    parameter int MIN_BYTES = 6
) (
    input  logic        clock,
    input  logic        nrst,
    input  logic        sop,
    input  logic        eop,
    input  logic        din_vld,
    input  logic [7:0]  din,
    output logic        busy,
    output logic        done,
    output logic        crc_ok,
    output logic        len_err,
    output logic [5:0]  byte_cnt,
    output logic [31:0] crc_o
);
    import pd_crc_pkg::*;

    localparam logic [5:0] MAX_C   = 6'(MAX_BYTES);
    localparam logic [5:0] MIN_C   = 6'(MIN_BYTES);
    localparam logic [5:0] CNT_SAT = 6'd63;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_start;
    logic        w_adv;
    logic        w_end;
    logic [5:0]  w_cnt_next;
    logic        w_over;
    logic        w_under;
    logic [5:0]  r_byte_cnt;
    logic        r_crc_ok;
    logic        r_len_err;
    logic [31:0] w_crc;
    logic [31:0] w_crc_next;

    pd_crc32_lfsr u_lfsr (
        .clock      (clock),
        .nrst       (nrst),
        .i_init     (w_start),
        .i_en       (w_start | w_adv),
        .i_data     (din),
        .o_crc      (w_crc),
        .o_crc_next (w_crc_next)
    );

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A valid sop restarts a frame from any state, including the DONE cycle.
    always_comb begin
        w_start      = din_vld & sop;
        w_adv        = din_vld & ~sop & (r_state == ST_RUN);
        w_end        = eop & (w_start | w_adv);
        w_state_next = r_state;
        w_cnt_next   = r_byte_cnt;
        case (r_state)
            ST_IDLE: if (w_start) w_state_next = ST_RUN;
            ST_RUN:  w_state_next = ST_RUN;
            ST_DONE: w_state_next = w_start ? ST_RUN : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
        if (w_end) begin
            w_state_next = ST_DONE;
        end
        if (w_start) begin
            w_cnt_next = 6'd1;
        end else if (w_adv && (r_byte_cnt != CNT_SAT)) begin
            w_cnt_next = r_byte_cnt + 6'd1;
        end
    end

    assign w_over  = (w_cnt_next > MAX_C);
    assign w_under = (w_cnt_next < MIN_C);

    // Overlength is flagged as soon as it happens; the ok/fail verdict lands with eop.
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            r_byte_cnt <= 6'd0;
            r_crc_ok   <= 1'b0;
            r_len_err  <= 1'b0;
        end else begin
            r_byte_cnt <= w_cnt_next;
            if (w_start) begin
                r_crc_ok  <= 1'b0;
                r_len_err <= eop;
            end else if (w_adv) begin
                r_len_err <= r_len_err | w_over | (eop & w_under);
                if (eop) begin
                    r_crc_ok <= (w_crc_next == CRC_RESIDUE) & ~w_over & ~w_under & ~r_len_err;
                end
            end
        end
    end

    assign busy     = (r_state == ST_RUN);
    assign done     = (r_state == ST_DONE);
    assign crc_ok   = r_crc_ok;
    assign len_err  = r_len_err;
    assign byte_cnt = r_byte_cnt;
    assign crc_o    = ~w_crc;

endmodule
